return_addr_stack: RTL and testbench

RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

---
 rtl/return_addr_stack.sv | 133 +++++++++++++
 tb/tb_return_addr_stack.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// Purpose : 8-entry x 16-bit circular return-address stack (push on call, pop on return).
// Latency : 1 clock from push to top_addr/count update; 1 clock from pop to pop_addr/pop_valid.
// Backpressure: none; push while full overwrites the oldest entry, pop while empty returns 0 (sticky flags record both).
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   push, push_addr      store push_addr as the new top (stored unmodified)
//   pop                  remove top; result appears on pop_addr with a 1-cycle pop_valid pulse
//   clear_err            synchronous clear of overflow/underflow (a same-cycle new error wins)
//   pop_addr, pop_valid  registered pop result
//   top_addr             current top entry from registered state, 0 when empty
//   count, empty, full   occupancy (0..8)
//   overflow, underflow  sticky error flags
module return_addr_stack (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] push_addr,
  input  logic        pop,
  input  logic        clear_err,
  output logic [15:0] pop_addr,
  output logic        pop_valid,
  output logic [15:0] top_addr,
  output logic [3:0]  count,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        underflow
);

  localparam int DEPTH = 8;

  // Storage carries no reset: it is only ever read through top_idx while count is non-zero.
  logic [15:0] mem_q [DEPTH];

  // ptr_q is the next free slot; the top entry lives one below it (mod 8).
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] pop_addr_q, pop_addr_d;
  logic        pop_valid_q, pop_valid_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [2:0]  top_idx;
  logic        is_empty;
  logic        is_full;

  assign top_idx  = ptr_q - 3'd1;
  assign is_empty = (count_q == 4'd0);
  assign is_full  = (count_q == 4'd8);

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    pop_addr_d  = pop_addr_q;
    pop_valid_d = pop;
    // Clear first, then any new error below re-sets the flag, so a coincident error wins.
    overflow_d  = overflow_q  & ~clear_err;
    underflow_d = underflow_q & ~clear_err;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;

    if (pop) begin
      if (is_empty) begin
        pop_addr_d  = 16'h0000;
        underflow_d = 1'b1;
        if (push) begin
          // Empty pop+push still performs the push.
          wr_en   = 1'b1;
          wr_idx  = ptr_q;
          ptr_d   = ptr_q + 3'd1;
          count_d = 4'd1;
        end
      end else begin
        pop_addr_d = mem_q[top_idx];
        if (push) begin
          // Return-then-call: replace the top in place, occupancy unchanged.
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          ptr_d   = top_idx;
          count_d = count_q - 4'd1;
        end
      end
    end else if (push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + 3'd1;
      // When full, ptr_q points at the oldest entry, so the write above discards it.
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= 3'd0;
      count_q     <= 4'd0;
      pop_addr_q  <= 16'h0000;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      pop_addr_q  <= pop_addr_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_addr;
    end
  end

  assign pop_addr  = pop_addr_q;
  assign pop_valid = pop_valid_q;
  assign top_addr  = is_empty ? 16'h0000 : mem_q[top_idx];
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: directed scenarios plus randomized traffic against a queue-based stack model.
module tb_return_addr_stack;

  logic        clk;
  logic        reset;
  logic        push;
  logic [15:0] push_addr;
  logic        pop;
  logic        clear_err;
  logic [15:0] pop_addr;
  logic        pop_valid;
  logic [15:0] top_addr;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: newest entry at the back of the queue.
  logic [15:0] stk[$];
  logic [15:0] m_pop_addr;
  bit          m_pop_valid;
  bit          m_ovf;
  bit          m_udf;

  return_addr_stack dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .clear_err (clear_err),
    .pop_addr  (pop_addr),
    .pop_valid (pop_valid),
    .top_addr  (top_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  function automatic logic [15:0] m_top();
    return (stk.size() == 0) ? 16'h0000 : stk[stk.size()-1];
  endfunction

  task automatic model_step(input bit p, input logic [15:0] a, input bit o, input bit c);
    bit new_ovf = 0;
    bit new_udf = 0;
    m_pop_valid = o;
    if (o) begin
      if (stk.size() == 0) begin
        m_pop_addr = 16'h0000;
        new_udf = 1;
        if (p) stk.push_back(a);
      end else begin
        m_pop_addr = stk[stk.size()-1];
        if (p) stk[stk.size()-1] = a;
        else void'(stk.pop_back());
      end
    end else if (p) begin
      if (stk.size() == 8) begin
        void'(stk.pop_front());
        new_ovf = 1;
      end
      stk.push_back(a);
    end
    if (c) begin
      m_ovf = 0;
      m_udf = 0;
    end
    m_ovf = m_ovf | new_ovf;
    m_udf = m_udf | new_udf;
  endtask

  task automatic model_reset();
    stk.delete();
    m_pop_addr  = 16'h0000;
    m_pop_valid = 0;
    m_ovf       = 0;
    m_udf       = 0;
  endtask

  // Apply one cycle of stimulus, advance the model, and return 1 ns after the edge.
  task automatic cycle(input bit p, input logic [15:0] a, input bit o, input bit c);
    push = p; push_addr = a; pop = o; clear_err = c;
    model_step(p, a, o, c);
    @(posedge clk);
    #1;
    push = 0; pop = 0; clear_err = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; push = 0; push_addr = 16'h0; pop = 0; clear_err = 0;
    model_reset();
    #1;
    n_vec++; if (count !== 4'd0)     begin n_err++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL rst_empty got=%b exp=1", empty); end
    n_vec++; if (full !== 1'b0)      begin n_err++; $display("FAIL rst_full got=%b exp=0", full); end
    n_vec++; if (top_addr !== 16'h0) begin n_err++; $display("FAIL rst_top got=%h exp=0000", top_addr); end
    n_vec++; if (pop_valid !== 1'b0 || pop_addr !== 16'h0)
      begin n_err++; $display("FAIL rst_pop got=%b/%h exp=0/0000", pop_valid, pop_addr); end
    n_vec++; if (overflow !== 1'b0 || underflow !== 1'b0)
      begin n_err++; $display("FAIL rst_flags got=%b%b exp=00", overflow, underflow); end
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_lifo();
    logic [15:0] exp_pop [3];
    exp_pop[0] = 16'h0006; exp_pop[1] = 16'h0004; exp_pop[2] = 16'h0002;
    do_reset();
    cycle(1, 16'h0002, 0, 0);
    n_vec++; if (count !== 4'd1 || top_addr !== 16'h0002)
      begin n_err++; $display("FAIL lifo_first_push got=%0d/%h exp=1/0002", count, top_addr); end
    cycle(1, 16'h0004, 0, 0);
    cycle(1, 16'h0006, 0, 0);
    n_vec++; if (count !== 4'd3 || top_addr !== 16'h0006)
      begin n_err++; $display("FAIL lifo_push3 got=%0d/%h exp=3/0006", count, top_addr); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 16'h0, 1, 0);
      n_vec++; if (pop_valid !== 1'b1 || pop_addr !== exp_pop[i])
        begin n_err++; $display("FAIL lifo_pop%0d got=%b/%h exp=1/%h", i, pop_valid, pop_addr, exp_pop[i]); end
    end
    cycle(0, 16'h0, 0, 0);
    n_vec++; if (pop_valid !== 1'b0 || pop_addr !== 16'h0002)
      begin n_err++; $display("FAIL lifo_hold got=%b/%h exp=0/0002", pop_valid, pop_addr); end
    n_vec++; if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || top_addr !== 16'h0)
      begin n_err++; $display("FAIL lifo_end got=e%b o%b u%b t%h exp=e1 o0 u0 t0000", empty, overflow, underflow, top_addr); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_a;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1, 16'(16'h0010 + 2*i), 0, 0);
      if (i == 7) begin
        n_vec++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0)
          begin n_err++; $display("FAIL ovf_full8 got=f%b c%0d o%b exp=f1 c8 o0", full, count, overflow); end
      end
    end
    n_vec++; if (overflow !== 1'b1 || count !== 4'd8 || top_addr !== 16'h0020)
      begin n_err++; $display("FAIL ovf_9th got=o%b c%0d t%h exp=o1 c8 t0020", overflow, count, top_addr); end
    for (int i = 0; i < 8; i++) begin
      exp_a = 16'(16'h0020 - 2*i);
      cycle(0, 16'h0, 1, 0);
      n_vec++; if (pop_valid !== 1'b1 || pop_addr !== exp_a)
        begin n_err++; $display("FAIL ovf_pop%0d got=%b/%h exp=1/%h", i, pop_valid, pop_addr, exp_a); end
    end
    n_vec++; if (empty !== 1'b1 || count !== 4'd0)
      begin n_err++; $display("FAIL ovf_drained got=e%b c%0d exp=e1 c0", empty, count); end
    cycle(0, 16'h0, 1, 0);
    n_vec++; if (pop_addr !== 16'h0000 || underflow !== 1'b1)
      begin n_err++; $display("FAIL ovf_lost got=%h u%b exp=0000 u1", pop_addr, underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(0, 16'h0, 1, 0);
    n_vec++; if (pop_valid !== 1'b1 || pop_addr !== 16'h0 || underflow !== 1'b1 || count !== 4'd0)
      begin n_err++; $display("FAIL udf_pop got=v%b a%h u%b c%0d exp=v1 a0000 u1 c0", pop_valid, pop_addr, underflow, count); end
    cycle(0, 16'h0, 0, 0);
    n_vec++; if (pop_valid !== 1'b0 || underflow !== 1'b1)
      begin n_err++; $display("FAIL udf_sticky got=v%b u%b exp=v0 u1", pop_valid, underflow); end
    cycle(0, 16'h0, 0, 1);
    n_vec++; if (underflow !== 1'b0)
      begin n_err++; $display("FAIL udf_clear got=%b exp=0", underflow); end
    cycle(0, 16'h0, 1, 1);
    n_vec++; if (underflow !== 1'b1)
      begin n_err++; $display("FAIL udf_set_wins got=%b exp=1", underflow); end
  endtask

  task automatic test_push_pop();
    do_reset();
    cycle(1, 16'h0100, 0, 0);
    cycle(1, 16'h0102, 0, 0);
    cycle(1, 16'h0200, 1, 0);
    n_vec++; if (pop_valid !== 1'b1 || pop_addr !== 16'h0102 || top_addr !== 16'h0200 || count !== 4'd2)
      begin n_err++; $display("FAIL pp_swap got=v%b a%h t%h c%0d exp=v1 a0102 t0200 c2", pop_valid, pop_addr, top_addr, count); end
    n_vec++; if (overflow !== 1'b0 || underflow !== 1'b0)
      begin n_err++; $display("FAIL pp_noerr got=%b%b exp=00", overflow, underflow); end
    cycle(1, 16'h1235, 0, 0);
    n_vec++; if (top_addr !== 16'h1235)
      begin n_err++; $display("FAIL pp_bit0 got=%h exp=1235", top_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 16'h0300, 0, 0);
    cycle(1, 16'h0302, 0, 0);
    cycle(0, 16'h0, 1, 0);
    #2;
    reset = 1;
    model_reset();
    #1;
    n_vec++; if (count !== 4'd0 || empty !== 1'b1 || top_addr !== 16'h0 || pop_valid !== 1'b0)
      begin n_err++; $display("FAIL arst_now got=c%0d e%b t%h v%b exp=c0 e1 t0000 v0", count, empty, top_addr, pop_valid); end
    @(posedge clk);
    #1;
    n_vec++; if (pop_valid !== 1'b0 || count !== 4'd0)
      begin n_err++; $display("FAIL arst_held got=v%b c%0d exp=v0 c0", pop_valid, count); end
    reset = 0;
    cycle(1, 16'h0500, 0, 0);
    n_vec++; if (count !== 4'd1 || top_addr !== 16'h0500)
      begin n_err++; $display("FAIL arst_first_edge got=c%0d t%h exp=c1 t0500", count, top_addr); end
  endtask

  task automatic test_push_pop_empty();
    do_reset();
    cycle(1, 16'h0400, 1, 0);
    n_vec++; if (pop_valid !== 1'b1 || pop_addr !== 16'h0 || underflow !== 1'b1 || count !== 4'd1 || top_addr !== 16'h0400)
      begin n_err++; $display("FAIL ppe got=v%b a%h u%b c%0d t%h exp=v1 a0000 u1 c1 t0400", pop_valid, pop_addr, underflow, count, top_addr); end
  endtask

  task automatic test_random();
    bit p, o, c;
    logic [15:0] a;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 99) < 8);
      a = 16'($urandom);
      cycle(p, a, o, c);
      n_vec++;
      if (pop_valid !== m_pop_valid || pop_addr !== m_pop_addr || top_addr !== m_top() ||
          count !== 4'(stk.size()) || empty !== (stk.size() == 0) || full !== (stk.size() == 8) ||
          overflow !== m_ovf || underflow !== m_udf) begin
        n_err++;
        $display("FAIL rand%0d got=v%b a%h t%h c%0d e%b f%b o%b u%b exp=v%b a%h t%h c%0d e%b f%b o%b u%b",
                 i, pop_valid, pop_addr, top_addr, count, empty, full, overflow, underflow,
                 m_pop_valid, m_pop_addr, m_top(), stk.size(), (stk.size() == 0), (stk.size() == 8), m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_async_reset();
    test_push_pop_empty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
